result_history_buffer: RTL and testbench
========================================

Name: result_history_buffer

Overview:
- Downstream consumer of both datapath ALU results, clocked at the 1 Hz display clock.
- Captures the low byte of each retired result into a circular history buffer.
- Drives the byte shown on the two-digit 7-segment mux.
- LIVE mode shows the newest result. REVIEW mode freezes capture and lets the user step back through history with a pushbutton.

Parameters:
- DEPTH, 16, number of history entries; power of two, minimum 4.
- DATA_W, 8, low bits of each ALU result stored and displayed.
- IDX_W, $clog2(DEPTH), pointer/offset width.

Ports:
- hz1_clk  input  1  display-rate clock; all state updates on its rising edge.
- n_rst  input  1  asynchronous active-low reset.
- res1_valid  input  1  datapath-1 result retired this hz1_clk cycle.
- res1  input  32  datapath-1 ALU result.
- res2_valid  input  1  datapath-2 result retired this hz1_clk cycle.
- res2  input  32  datapath-2 ALU result.
- btn_mode  input  1  level; rising edge toggles LIVE/REVIEW.
- btn_step  input  1  level; rising edge steps to the next-older entry in REVIEW.
- disp_value  output  DATA_W  byte for the 7-seg mux.
- disp_index  output  IDX_W  age of the displayed entry; 0 = newest.
- review_mode  output  1  1 while in REVIEW.
- count  output  IDX_W+1  valid entries, saturating at DEPTH.
- overflow  output  1  sticky; set when an entry is overwritten.
- dropped  output  8  results discarded during the current/last REVIEW; saturates at 255.

Behaviour:
- Reset (async, n_rst low): buffer contents don't-care; wr_ptr=0, count=0, view_ofs=0, state=LIVE; all outputs 0; button history registers cleared to 0.
- All inputs are synchronous to hz1_clk; a button press must be held at least one hz1_clk period.
- Edge detect: internal btn_mode_q/btn_step_q registers; an event fires when the input is 1 and its _q is 0.
- FSM, two states:
  - LIVE -> REVIEW on a btn_mode event when count>0. The event is ignored when count==0.
  - REVIEW -> LIVE on a btn_mode event.
- LIVE capture, res1 only valid: mem[wr_ptr]<=res1[DATA_W-1:0]; wr_ptr+=1.
- LIVE capture, res2 only valid: mem[wr_ptr]<=res2[DATA_W-1:0]; wr_ptr+=1.
- LIVE capture, both valid: mem[wr_ptr]<=res1, mem[wr_ptr+1]<=res2; wr_ptr+=2. res2 is the newer entry.
- Pointer wrap: wr_ptr wraps modulo DEPTH.
- count saturates at DEPTH.
- overflow set whenever a write lands on a valid entry: count==DEPTH before the write, or count==DEPTH-1 with a double write.
- disp_value in LIVE: registered; on a capturing edge it takes the newest byte written that edge. Latency is 1 edge. With no capture it holds. disp_index=0 in LIVE.
- Entering REVIEW:
  - view_ofs=0; dropped cleared to 0.
  - disp_value = mem[wr_ptr-1], same value as displayed; disp_index=0; review_mode=1 on that edge.
- Writes in REVIEW: blocked. Each valid result increments dropped, +2 for a double, saturating at 255. count, wr_ptr and overflow are unchanged.
- Stepping in REVIEW:
  - A btn_step event sets view_ofs = (view_ofs+1 == count) ? 0 : view_ofs+1.
  - disp_value = mem[wr_ptr-1-view_ofs] (mod DEPTH); disp_index=view_ofs. Registered, visible after the step edge.
- btn_step in LIVE: ignored.
- btn_mode and btn_step events on the same edge: btn_mode wins and btn_step is ignored.
- Exiting REVIEW:
  - Results valid on the exit edge are captured per the LIVE rules.
  - disp_value = newest written byte, or mem[wr_ptr-1] if none.
  - disp_index=0; review_mode=0; dropped holds its value until the next REVIEW entry.
- Reset mid-REVIEW: immediate return to the reset state; dropped and overflow cleared.
- Implementation: memory is a flop array (no RAM inference required) with no read-during-write hazard, because REVIEW blocks writes.

Test Plan:
- Reset, then res1_valid=1 with res1=0x0000_1234 for 1 edge -> disp_value=0x34, count=1, overflow=0, review_mode=0.
- Single edge with res1=0xAA, res2=0xBB, both valid -> count=2, disp_value=0xBB; enter REVIEW -> disp_value=0xBB, idx 0; step -> 0xAA, idx 1; step -> 0xBB, idx 0 (wrap).
- 17 single writes 0x01..0x11 (DEPTH=16) -> count=16, overflow=1 after the 17th. REVIEW with 15 steps -> disp_value=0x02, disp_index=15; one more step -> 0x11, idx 0.
- Enter REVIEW, apply 3 edges with both results valid -> dropped=6, count unchanged, disp_value frozen; exit with res1=0x5C valid on the exit edge -> disp_value=0x5C, count+1.
- btn_mode pulse with count=0 -> review_mode stays 0. btn_mode held high 4 edges -> exactly one toggle. btn_mode and btn_step rising together in LIVE -> REVIEW entered, view_ofs=0.
- Assert n_rst low mid-REVIEW, asynchronously between edges -> all outputs 0 immediately; after release, the first capture shows at disp_value with count=1.

Source files
------------

// File: rtl/result_history_buffer.sv
// result_history_buffer: circular history of retired ALU result bytes with LIVE/REVIEW display
// Ports: hz1_clk / n_rst are the display clock and async active-low reset; res1/res2 with
// their valids are the retired datapath results; btn_mode / btn_step are level buttons;
// disp_value / disp_index drive the 7-seg mux; review_mode, count, overflow and dropped
// report buffer status.
module result_history_buffer #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              hz1_clk,
    input  logic              n_rst,
    input  logic              res1_valid,
    input  logic [31:0]       res1,
    input  logic              res2_valid,
    input  logic [31:0]       res2,
    input  logic              btn_mode,
    input  logic              btn_step,
    output logic [DATA_W-1:0] disp_value,
    output logic [IDX_W-1:0]  disp_index,
    output logic              review_mode,
    output logic [IDX_W:0]    count,
    output logic              overflow,
    output logic [7:0]        dropped
);
    typedef enum logic {LIVE, REVIEW} state_t;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d, view_ofs_q, view_ofs_d, rd_idx, wr2_idx;
    logic [IDX_W:0]    count_q, count_d, ofs_inc;
    logic [DATA_W-1:0] disp_q, disp_d;
    logic              ovf_q, ovf_d, btn_mode_q, btn_step_q;
    logic [7:0]        dropped_q, dropped_d;
    logic              mode_ev, step_ev, entering, exiting, cap, stepping, full_hit;
    logic [1:0]        n_new;
    logic [IDX_W+1:0]  count_sum;
    logic [8:0]        drop_sum;
    logic              unused_hi;

    assign unused_hi = ^{res1[31:DATA_W], res2[31:DATA_W]};
    assign mode_ev   = btn_mode & ~btn_mode_q;
    assign step_ev   = btn_step & ~btn_step_q;
    // Entering REVIEW with an empty buffer is refused; the entry edge itself is frozen.
    assign entering  = state_q == LIVE && mode_ev && count_q != '0;
    assign exiting   = state_q == REVIEW && mode_ev;
    assign cap       = (state_q == LIVE && !entering) || exiting;
    assign stepping  = state_q == REVIEW && !mode_ev && step_ev;
    assign n_new     = {1'b0, res1_valid} + {1'b0, res2_valid};
    assign count_sum = {1'b0, count_q} + (IDX_W+2)'(n_new);
    assign drop_sum  = {1'b0, dropped_q} + 9'(n_new);
    assign ofs_inc   = {1'b0, view_ofs_q} + 1'b1;
    // res2 lands after res1 when both retire, so it becomes the newer entry.
    assign wr2_idx   = wr_ptr_q + IDX_W'(res1_valid);
    assign full_hit  = cap && count_sum > (IDX_W+2)'(DEPTH);

    always_comb begin
        state_d    = entering ? REVIEW : exiting ? LIVE : state_q;
        view_ofs_d = stepping ? (ofs_inc == count_q ? '0 : ofs_inc[IDX_W-1:0]) :
                     (entering || exiting) ? '0 : view_ofs_q;
        wr_ptr_d   = cap ? wr_ptr_q + IDX_W'(n_new) : wr_ptr_q;
        count_d    = full_hit ? (IDX_W+1)'(DEPTH) : cap ? count_sum[IDX_W:0] : count_q;
        ovf_d      = ovf_q | full_hit;
        dropped_d  = entering ? '0 :
                     (state_q == REVIEW && !exiting) ? (drop_sum[8] ? 8'hFF : drop_sum[7:0]) :
                     dropped_q;
        rd_idx     = wr_ptr_q - IDX_W'(1) - view_ofs_d;
        // Memory is frozen outside LIVE, so re-reading it every REVIEW edge is stable.
        disp_d     = (cap && res2_valid) ? res2[DATA_W-1:0] :
                     (cap && res1_valid) ? res1[DATA_W-1:0] :
                     (state_d == REVIEW || exiting) ? mem_q[rd_idx] : disp_q;
    end

    always_ff @(posedge hz1_clk) begin
        if (cap && res1_valid) mem_q[wr_ptr_q] <= res1[DATA_W-1:0];
        if (cap && res2_valid) mem_q[wr2_idx] <= res2[DATA_W-1:0];
    end

    always_ff @(posedge hz1_clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= LIVE;
            wr_ptr_q   <= '0;
            view_ofs_q <= '0;
            count_q    <= '0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
            dropped_q  <= '0;
            btn_mode_q <= 1'b0;
            btn_step_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            view_ofs_q <= view_ofs_d;
            count_q    <= count_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            dropped_q  <= dropped_d;
            btn_mode_q <= btn_mode;
            btn_step_q <= btn_step;
        end
    end

    assign disp_value  = disp_q;
    assign disp_index  = view_ofs_q;
    assign review_mode = state_q == REVIEW;
    assign count       = count_q;
    assign overflow    = ovf_q;
    assign dropped     = dropped_q;
endmodule

// File: tb/tb_result_history_buffer.sv
// tb_result_history_buffer: vector table, corner sequences and random run against a queue model
module tb_result_history_buffer;
    localparam int DEPTH = 16;

    logic        hz1_clk = 1'b0, n_rst = 1'b0;
    logic        res1_valid = 1'b0, res2_valid = 1'b0, btn_mode = 1'b0, btn_step = 1'b0;
    logic [31:0] res1 = '0, res2 = '0;
    logic [7:0]  disp_value, dropped;
    logic [3:0]  disp_index;
    logic        review_mode, overflow;
    logic [4:0]  count;
    int          n_cmp = 0, n_bad = 0;

    always #5 hz1_clk = ~hz1_clk;

    result_history_buffer #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .hz1_clk(hz1_clk), .n_rst(n_rst),
        .res1_valid(res1_valid), .res1(res1), .res2_valid(res2_valid), .res2(res2),
        .btn_mode(btn_mode), .btn_step(btn_step),
        .disp_value(disp_value), .disp_index(disp_index), .review_mode(review_mode),
        .count(count), .overflow(overflow), .dropped(dropped)
    );

    // Reference model: history as a queue, newest at the back, oldest dropped when full.
    byte unsigned hist[$];
    bit           m_rev, m_ovf, pm, ps;
    int           m_ofs, m_drop;
    byte unsigned m_disp;

    task automatic m_reset();
        hist.delete();
        m_rev = 0; m_ovf = 0; pm = 0; ps = 0; m_ofs = 0; m_drop = 0; m_disp = 0;
    endtask

    task automatic m_push(input byte unsigned b);
        if (hist.size() == DEPTH) begin
            hist.delete(0);
            m_ovf = 1;
        end
        hist.push_back(b);
        m_disp = b;
    endtask

    task automatic m_edge(input bit r1v, input logic [31:0] r1, input bit r2v,
                          input logic [31:0] r2, input bit bm, input bit bs);
        bit me, se;
        me = bm && !pm;
        se = bs && !ps;
        pm = bm;
        ps = bs;
        if (!m_rev) begin
            if (me && hist.size() > 0) begin
                m_rev = 1; m_ofs = 0; m_drop = 0; m_disp = hist[hist.size()-1];
            end else begin
                if (r1v) m_push(r1[7:0]);
                if (r2v) m_push(r2[7:0]);
            end
        end else if (me) begin
            m_rev = 0; m_ofs = 0;
            if (r1v) m_push(r1[7:0]);
            if (r2v) m_push(r2[7:0]);
            if (!r1v && !r2v) m_disp = hist[hist.size()-1];
        end else begin
            m_drop = m_drop + int'(r1v) + int'(r2v);
            if (m_drop > 255) m_drop = 255;
            if (se) m_ofs = (m_ofs + 1 == hist.size()) ? 0 : m_ofs + 1;
            m_disp = hist[hist.size()-1-m_ofs];
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("disp_value", disp_value, m_disp);
        chk("disp_index", disp_index, m_rev ? m_ofs : 0);
        chk("review_mode", review_mode, m_rev);
        chk("count", count, hist.size());
        chk("overflow", overflow, m_ovf);
        chk("dropped", dropped, m_drop);
    endtask

    task automatic cyc(input bit r1v, input logic [31:0] r1, input bit r2v,
                       input logic [31:0] r2, input bit bm, input bit bs);
        res1_valid = r1v; res1 = r1; res2_valid = r2v; res2 = r2;
        btn_mode = bm; btn_step = bs;
        @(posedge hz1_clk);
        m_edge(r1v, r1, r2v, r2, bm, bs);
        #1;
        compare_model();
    endtask

    task automatic idle(input bit bm, input bit bs);
        cyc(0, 0, 0, 0, bm, bs);
    endtask

    task automatic do_reset();
        res1_valid = 0; res2_valid = 0; btn_mode = 0; btn_step = 0;
        n_rst = 0;
        @(posedge hz1_clk);
        #1;
        m_reset();
        compare_model();
        n_rst = 1;
    endtask

    typedef struct {
        bit          r1v;
        logic [31:0] r1;
        bit          r2v;
        logic [31:0] r2;
        bit          bm, bs;
        logic [7:0]  e_disp;
        logic [3:0]  e_idx;
        bit          e_rev;
        logic [4:0]  e_cnt;
        bit          e_ovf;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t vt[11];

    initial begin
        bit          r1v, r2v, bm, bs;
        logic [31:0] r1, r2;

        vt[0]  = '{1, 32'h0000_1234, 0, 0, 0, 0, 8'h34, 0, 0, 1, 0, 0};
        vt[1]  = '{1, 32'h0000_00AA, 1, 32'h0000_00BB, 0, 0, 8'hBB, 0, 0, 3, 0, 0};
        vt[2]  = '{0, 0, 0, 0, 1, 0, 8'hBB, 0, 1, 3, 0, 0};
        vt[3]  = '{0, 0, 0, 0, 0, 1, 8'hAA, 1, 1, 3, 0, 0};
        vt[4]  = '{0, 0, 0, 0, 0, 0, 8'hAA, 1, 1, 3, 0, 0};
        vt[5]  = '{0, 0, 0, 0, 0, 1, 8'h34, 2, 1, 3, 0, 0};
        vt[6]  = '{0, 0, 0, 0, 0, 0, 8'h34, 2, 1, 3, 0, 0};
        vt[7]  = '{0, 0, 0, 0, 0, 1, 8'hBB, 0, 1, 3, 0, 0};
        vt[8]  = '{0, 0, 0, 0, 0, 0, 8'hBB, 0, 1, 3, 0, 0};
        vt[9]  = '{0, 0, 0, 0, 1, 0, 8'hBB, 0, 0, 3, 0, 0};
        vt[10] = '{1, 32'hFFFF_FF77, 0, 0, 0, 0, 8'h77, 0, 0, 4, 0, 0};

        do_reset();
        chk("reset_disp", disp_value, 0);
        chk("reset_count", count, 0);
        for (int i = 0; i < 11; i++) begin
            cyc(vt[i].r1v, vt[i].r1, vt[i].r2v, vt[i].r2, vt[i].bm, vt[i].bs);
            chk($sformatf("vec%0d_disp", i), disp_value, vt[i].e_disp);
            chk($sformatf("vec%0d_idx", i), disp_index, vt[i].e_idx);
            chk($sformatf("vec%0d_rev", i), review_mode, vt[i].e_rev);
            chk($sformatf("vec%0d_cnt", i), count, vt[i].e_cnt);
            chk($sformatf("vec%0d_ovf", i), overflow, vt[i].e_ovf);
            chk($sformatf("vec%0d_drop", i), dropped, vt[i].e_drop);
        end

        // Fill past capacity, then walk the whole history.
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            cyc(1, i, 0, 0, 0, 0);
            if (i == 16) chk("ovf_before_wrap", overflow, 0);
        end
        chk("full_count", count, 16);
        chk("full_ovf", overflow, 1);
        idle(1, 0);
        idle(0, 0);
        for (int i = 0; i < 15; i++) begin
            idle(0, 1);
            idle(0, 0);
        end
        chk("oldest_disp", disp_value, 8'h02);
        chk("oldest_idx", disp_index, 15);
        idle(0, 1);
        chk("wrap_disp", disp_value, 8'h11);
        chk("wrap_idx", disp_index, 0);

        // Results dropped while reviewing, capture on the exit edge.
        do_reset();
        cyc(1, 32'h10, 0, 0, 0, 0);
        cyc(1, 32'h20, 0, 0, 0, 0);
        cyc(1, 32'h30, 0, 0, 0, 0);
        idle(1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 32'h41 + i, 1, 32'h51 + i, 0, 0);
        chk("drop_cnt", dropped, 6);
        chk("drop_count_hold", count, 3);
        chk("drop_disp_frozen", disp_value, 8'h30);
        cyc(1, 32'h5C, 0, 0, 1, 0);
        chk("exit_disp", disp_value, 8'h5C);
        chk("exit_count", count, 4);
        chk("exit_drop_hold", dropped, 6);
        chk("exit_live", review_mode, 0);

        // Button edge cases.
        do_reset();
        idle(1, 0);
        chk("empty_mode_ignored", review_mode, 0);
        idle(0, 0);
        cyc(1, 32'h21, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            idle(1, 0);
            chk($sformatf("held_mode_%0d", i), review_mode, 1);
        end
        idle(0, 0);
        idle(1, 0);
        chk("exit_after_hold", review_mode, 0);
        idle(0, 0);
        cyc(1, 32'h22, 0, 0, 0, 0);
        idle(1, 1);
        chk("mode_wins_rev", review_mode, 1);
        chk("mode_wins_idx", disp_index, 0);
        chk("mode_wins_disp", disp_value, 8'h22);
        idle(1, 0);
        idle(1, 1);
        chk("step_after_tie", disp_value, 8'h21);

        // Asynchronous reset between edges while reviewing.
        res1_valid = 0; res2_valid = 0; btn_mode = 0; btn_step = 0;
        #3;
        n_rst = 0;
        #1;
        m_reset();
        chk("async_rev", review_mode, 0);
        chk("async_drop", dropped, 0);
        compare_model();
        @(posedge hz1_clk);
        #1;
        n_rst = 1;
        cyc(1, 32'hABCD_EF9A, 0, 0, 0, 0);
        chk("post_reset_disp", disp_value, 8'h9A);
        chk("post_reset_count", count, 1);

        // Random traffic against the model; valids are withheld on REVIEW-entry edges.
        do_reset();
        bm = 0; bs = 0;
        for (int i = 0; i < 1500; i++) begin
            r1v = $urandom_range(0, 2) != 0;
            r2v = $urandom_range(0, 2) == 0;
            r1 = $urandom;
            r2 = $urandom;
            if ($urandom_range(0, 9) == 0) bm = ~bm;
            if ($urandom_range(0, 2) == 0) bs = ~bs;
            if (!m_rev && bm && !pm && hist.size() > 0) begin
                r1v = 0;
                r2v = 0;
            end
            cyc(r1v, r1, r2v, r2, bm, bs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
